shared_mem_arbiter: RTL and testbench

Parametrised unified memory subsystem: one word-addressed SRAM array shared by NumPorts requesters (port 0 = instruction fetch, port 1 = load/store, extra ports for future masters such as a debug loader or DMA).
Successor to the separate instruction/data memory tops. Adds round-robin arbitration, per-port in-flight tracking and configurable read latency on top of the existing request/we_re/mask/valid handshake.
Sits between core and backing storage inside the core top level.

---
 rtl/mem_pkg.sv | 14 +
 rtl/shared_mem_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/shared_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_shared_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the unified memory subsystem: port ids and read-pipeline tags.
package mem_pkg;

  localparam int MaxPorts = 8;

  // Wide enough for any legal port count; narrower configs leave upper bits zero.
  typedef logic [$clog2(MaxPorts)-1:0] port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port_id;
  } rd_meta_t;

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Per-port request/response bundle between requesters and the shared memory.
interface shared_mem_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int Address   = 8,
  parameter int NumPorts  = 2
);
  localparam int BytesPerWord = DataWidth / 8;

  logic [NumPorts-1:0]                   request;
  logic [NumPorts-1:0]                   we_re;
  logic [NumPorts-1:0][BytesPerWord-1:0] mask;
  logic [NumPorts-1:0][Address-1:0]      address;
  logic [NumPorts-1:0][DataWidth-1:0]    data_in;
  logic [NumPorts-1:0]                   valid;
  logic [NumPorts-1:0][DataWidth-1:0]    data_out;
  logic [NumPorts-1:0]                   busy;

  modport master (
    output request, we_re, mask, address, data_in,
    input  valid, data_out, busy
  );

  modport slave (
    input  request, we_re, mask, address, data_in,
    output valid, data_out, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a pointer that moves past each winner.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_grant_vld,
  output port_id_t     o_grant_id
);

  port_id_t     r_ptr;
  logic [N-1:0] w_grant;
  logic         w_vld;
  port_id_t     w_id;

  // Search pointer..N-1 first, then wrap to 0..pointer-1
  always_comb begin
    w_vld   = 1'b0;
    w_id    = r_ptr;
    w_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_vld && i_req[i] && (i >= int'(r_ptr))) begin
        w_vld = 1'b1;
        w_id  = port_id_t'(i);
      end else begin
        w_vld = w_vld;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_vld && i_req[i] && (i < int'(r_ptr))) begin
        w_vld = 1'b1;
        w_id  = port_id_t'(i);
      end else begin
        w_vld = w_vld;
      end
    end
    for (int i = 0; i < N; i++) begin
      w_grant[i] = w_vld && (w_id == port_id_t'(i));
    end
  end

  // Pointer advances to the port after the winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 3'd0;
    end else if (w_vld) begin
      r_ptr <= (w_id == port_id_t'(N - 1)) ? 3'd0 : w_id + 3'd1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_vld = w_vld;
  assign o_grant_id  = w_id;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Word-addressed SRAM shared by NumPorts requesters with round-robin grants,
// per-port busy tracking and a ReadLatency-deep tagged read pipeline.
module shared_mem_arbiter
  import mem_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int Address     = 8,
  parameter int NumPorts    = 2,
  parameter int ReadLatency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_mem_arbiter_if.slave  bus
);

  localparam int BytesPerWord = DataWidth / 8;
  localparam int Depth        = 2 ** Address;

  logic [NumPorts-1:0]                w_eligible;
  logic [NumPorts-1:0]                w_grant;
  logic                               w_gnt_vld;
  port_id_t                           w_gnt_id;
  logic                               w_we;
  logic [BytesPerWord-1:0]            w_mask;
  logic [Address-1:0]                 w_addr;
  logic [DataWidth-1:0]               w_wdata;
  logic [DataWidth-1:0]               w_rd_data;
  logic [DataWidth-1:0]               w_done_data;
  rd_meta_t                           w_rd_meta;
  rd_meta_t                           w_done_meta;
  logic [NumPorts-1:0]                w_rd_done;
  logic [DataWidth-1:0]               r_mem [Depth];
  logic [NumPorts-1:0]                r_valid;
  logic [NumPorts-1:0]                r_busy;
  logic [NumPorts-1:0][DataWidth-1:0] r_data_out;

  assign w_eligible = bus.request & ~r_busy;

  rr_arbiter #(.N(NumPorts)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_eligible),
    .o_grant     (w_grant),
    .o_grant_vld (w_gnt_vld),
    .o_grant_id  (w_gnt_id)
  );

  // One-hot grant selects the winning port's request fields
  always_comb begin
    w_we    = 1'b0;
    w_mask  = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int p = 0; p < NumPorts; p++) begin
      w_we    = w_we | (w_grant[p] & bus.we_re[p]);
      w_mask  = w_mask | ({BytesPerWord{w_grant[p]}} & bus.mask[p]);
      w_addr  = w_addr | ({Address{w_grant[p]}} & bus.address[p]);
      w_wdata = w_wdata | ({DataWidth{w_grant[p]}} & bus.data_in[p]);
    end
  end

  // Byte-lane writes; the array is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_gnt_vld && w_we) begin
      for (int b = 0; b < BytesPerWord; b++) begin
        if (w_mask[b]) begin
          r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign w_rd_data = r_mem[w_addr];
  assign w_rd_meta = '{valid: w_gnt_vld & ~w_we, port_id: w_gnt_id};

  // The output register is the final stage, so only ReadLatency-1 stages live here.
  if (ReadLatency == 1) begin : g_lat1
    assign w_done_meta = w_rd_meta;
    assign w_done_data = w_rd_data;
  end else begin : g_pipe
    rd_meta_t             r_meta [ReadLatency-1];
    logic [DataWidth-1:0] r_data [ReadLatency-1];

    // Tagged read pipeline; reset drops reads in flight
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < ReadLatency - 1; s++) begin
          r_meta[s] <= '0;
          r_data[s] <= '0;
        end
      end else begin
        r_meta[0] <= w_rd_meta;
        r_data[0] <= w_rd_data;
        for (int s = 1; s < ReadLatency - 1; s++) begin
          r_meta[s] <= r_meta[s-1];
          r_data[s] <= r_data[s-1];
        end
      end
    end

    assign w_done_meta = r_meta[ReadLatency-2];
    assign w_done_data = r_data[ReadLatency-2];
  end

  // Decode the completing read's tag to a per-port strobe
  always_comb begin
    w_rd_done = '0;
    for (int p = 0; p < NumPorts; p++) begin
      w_rd_done[p] = w_done_meta.valid && (w_done_meta.port_id == port_id_t'(p));
    end
  end

  // Busy spans grant through the valid cycle so a held request is not re-granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_busy     <= '0;
      r_data_out <= '0;
    end else begin
      r_valid <= (w_grant & {NumPorts{w_we}}) | w_rd_done;
      r_busy  <= (r_busy & ~r_valid) | w_grant;
      for (int p = 0; p < NumPorts; p++) begin
        if (w_rd_done[p]) begin
          r_data_out[p] <= w_done_data;
        end else begin
          r_data_out[p] <= r_data_out[p];
        end
      end
    end
  end

  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Randomized and directed bench for shared_mem_arbiter against a transaction-level model.
module tb_shared_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NP = 4;
  localparam int RL = 2;
  localparam int BW = DW / 8;

  logic clk;
  logic rst;

  shared_mem_arbiter_if #(.DataWidth(DW), .Address(AW), .NumPorts(NP)) bus ();

  shared_mem_arbiter #(
    .DataWidth(DW), .Address(AW), .NumPorts(NP), .ReadLatency(RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_bad;

  // Model: memory image, one outstanding transaction per port, RR pointer
  logic [DW-1:0] m_mem   [0:(1<<AW)-1];
  bit            m_pend  [NP];
  int            m_done  [NP];
  bit            m_rd    [NP];
  logic [DW-1:0] m_rdata [NP];
  logic [DW-1:0] m_dout  [NP];
  int            m_ptr;
  int            edge_n;

  bit            d_act   [NP];
  logic [NP-1:0] rnd_en;
  int            rnd_rate;
  int            rnd_wr;
  int            n_cmpl  [NP];
  logic [NP-1:0] prev_busy;
  int            obs[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic issue(input int p, input bit we, input logic [BW-1:0] mk,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.request[p] = 1'b1;
    bus.we_re[p]   = we;
    bus.mask[p]    = mk;
    bus.address[p] = a;
    bus.data_in[p] = d;
    d_act[p]       = 1'b1;
  endtask

  // One clock: check outputs, update requesters, model the next edge's grant, advance.
  task automatic step();
    logic [NP-1:0] ev;
    logic [NP-1:0] eb;
    bit            granted;
    int            q;
    logic [AW-1:0] a;
    ev = '0;
    eb = '0;
    granted = 1'b0;
    for (int p = 0; p < NP; p++) begin
      eb[p] = m_pend[p];
      ev[p] = m_pend[p] && (m_done[p] == edge_n);
      if (ev[p] && m_rd[p]) m_dout[p] = m_rdata[p];
    end
    chk("valid", bus.valid, ev);
    chk("busy", bus.busy, eb);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("data_out%0d", p), bus.data_out[p], m_dout[p]);
      if (bus.busy[p] && !prev_busy[p]) obs.push_back(p);
      if (ev[p]) begin
        m_pend[p] = 1'b0;
        d_act[p]  = 1'b0;
        n_cmpl[p]++;
      end
    end
    prev_busy = bus.busy;
    for (int p = 0; p < NP; p++) begin
      if (!d_act[p]) begin
        if (rnd_en[p] && ($urandom_range(99) < rnd_rate))
          issue(p, ($urandom_range(99) < rnd_wr), BW'($urandom),
                AW'($urandom_range(15)), $urandom);
        else
          bus.request[p] = 1'b0;
      end
    end
    for (int k = 0; k < NP; k++) begin
      q = (m_ptr + k) % NP;
      if (!granted && bus.request[q] && !eb[q]) begin
        granted = 1'b1;
        a = bus.address[q];
        if (bus.we_re[q]) begin
          for (int b = 0; b < BW; b++)
            if (bus.mask[q][b]) m_mem[a][8*b +: 8] = bus.data_in[q][8*b +: 8];
          m_rd[q]   = 1'b0;
          m_done[q] = edge_n + 1;
        end else begin
          m_rd[q]    = 1'b1;
          m_rdata[q] = m_mem[a];
          m_done[q]  = edge_n + RL;
        end
        m_pend[q] = 1'b1;
        m_ptr     = (q + 1) % NP;
      end
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic wait_done(input int p, output int n, output int nb);
    n = 0;
    nb = 0;
    while (d_act[p] && n < 40) begin
      if (bus.busy[p]) nb++;
      step();
      n++;
    end
    chk($sformatf("done_p%0d", p), d_act[p], 1'b0);
  endtask

  task automatic drain();
    int n;
    bit any;
    n = 0;
    any = 1'b1;
    while (any && n < 200) begin
      any = 1'b0;
      for (int p = 0; p < NP; p++) any |= d_act[p];
      if (any) step();
      n++;
    end
    chk("drain", any, 1'b0);
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_pend[p] = 1'b0;
      m_dout[p] = '0;
      d_act[p]  = 1'b0;
    end
    m_ptr = 0;
    prev_busy = '0;
    bus.request = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    int c0;
    int c1;
    int alt_bad;
    n_total = 0;
    n_bad = 0;
    edge_n = 0;
    rnd_en = '0;
    rnd_rate = 0;
    rnd_wr = 0;
    for (int p = 0; p < NP; p++) n_cmpl[p] = 0;
    bus.we_re = '0;
    bus.mask = '0;
    bus.address = '0;
    bus.data_in = '0;
    rst = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid, '0);
    chk("rst_busy", bus.busy, '0);
    chk("rst_dout", bus.data_out, '0);
    rst = 1'b1;

    for (int a = 0; a < 16; a++) begin
      issue(0, 1'b1, 4'hF, AW'(a), $urandom);
      wait_done(0, n, nb);
    end

    // Masked write, zero-mask write, read latency and busy width
    issue(1, 1'b1, 4'b1111, 8'h10, 32'hAABBCCDD);
    wait_done(1, n, nb);
    chk("wr_lat", n, 2);
    chk("wr_busy_cycles", nb, 1);
    issue(1, 1'b1, 4'b0101, 8'h10, 32'h11223344);
    wait_done(1, n, nb);
    issue(0, 1'b0, 4'b0000, 8'h10, 32'h0);
    wait_done(0, n, nb);
    chk("rd_lat", n, RL + 1);
    chk("rd_busy_cycles", nb, RL);
    chk("masked_word", bus.data_out[0], 32'hAA22CC44);
    issue(1, 1'b1, 4'b0000, 8'h10, 32'hFFFFFFFF);
    wait_done(1, n, nb);
    chk("zero_mask_lat", n, 2);
    issue(2, 1'b0, 4'b1111, 8'h10, 32'h0);
    wait_done(2, n, nb);
    chk("zero_mask_unchanged", bus.data_out[2], 32'hAA22CC44);

    // Read granted the cycle after a write to the same word sees the new data
    issue(1, 1'b1, 4'b1111, 8'h3F, 32'hDEADBEEF);
    step();
    issue(0, 1'b0, 4'b0000, 8'h3F, 32'h0);
    drain();
    chk("write_first", bus.data_out[0], 32'hDEADBEEF);

    // Pointer left at 2 by a port-1 grant; then all ports request at once
    issue(1, 1'b1, 4'b1111, 8'h05, 32'h0BADF00D);
    wait_done(1, n, nb);
    obs.delete();
    for (int p = 0; p < NP; p++) issue(p, 1'b0, 4'b0000, AW'(p + 1), 32'h0);
    drain();
    chk("order_len", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("order0", obs[0], 2);
      chk("order1", obs[1], 3);
      chk("order2", obs[2], 0);
      chk("order3", obs[3], 1);
    end

    // Two ports reading back-to-back must alternate fairly
    obs.delete();
    c0 = n_cmpl[0];
    c1 = n_cmpl[1];
    rnd_en = 4'b0011;
    rnd_rate = 100;
    rnd_wr = 0;
    repeat (20) step();
    c0 = n_cmpl[0] - c0;
    c1 = n_cmpl[1] - c1;
    alt_bad = 0;
    for (int i = 1; i < obs.size(); i++) if (obs[i] == obs[i-1]) alt_bad++;
    chk("contention_alternate", alt_bad, 0);
    chk("contention_fair", ((c0 - c1) <= 1) && ((c1 - c0) <= 1), 1'b1);
    chk("contention_grants", obs.size() >= 12, 1'b1);
    rnd_en = '0;
    drain();

    rnd_en = 4'hF;
    rnd_rate = 60;
    rnd_wr = 40;
    repeat (600) step();
    rnd_en = '0;
    drain();

    // Reset while a read is in flight: it never completes, pointer returns to 0
    issue(0, 1'b0, 4'b0000, 8'h03, 32'h0);
    step();
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", bus.busy, '0);
    chk("midrst_dout", bus.data_out, '0);
    repeat (3) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      chk("midrst_valid", bus.valid, '0);
    end
    rst = 1'b1;
    obs.delete();
    for (int p = 0; p < NP; p++) issue(p, 1'b0, 4'b0000, AW'(p + 8), 32'h0);
    drain();
    chk("rst_order_len", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("rst_order0", obs[0], 0);
      chk("rst_order1", obs[1], 1);
      chk("rst_order2", obs[2], 2);
      chk("rst_order3", obs[3], 3);
    end

    rnd_en = 4'hF;
    rnd_rate = 70;
    rnd_wr = 50;
    repeat (300) step();
    rnd_en = '0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
